washing_machine_prog: RTL and testbench

//  Programmable washing-machine controller; successor of the fixed IDLE/H20/WARM/WASH/PUMP sequencer.

---
 rtl/washing_pkg.sv | 49 ++++
 rtl/wm_phase_timer.sv | 27 ++
 rtl/washing_machine_prog.sv | 145 ++++++++++++++
 tb/tb_washing_machine_prog.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/washing_pkg.sv
// rtl/washing_pkg.sv - shared state encoding, actuator bundle and decode helpers for the washer controller
package washing_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      HEAT  = 3'd2,
      WASH  = 3'd3,
      DRAIN = 3'd4,
      SPIN  = 3'd5,
      DONE  = 3'd6,
      FAULT = 3'd7
   } state_e;

   typedef struct packed {
      logic heater;
      logic valve;
      logic motor;
      logic spin;
      logic pump;
      logic door_lock;
   } act_t;

   function automatic bit cycles_ok(input int v, input int w);
      return (v >= 1) && (longint'(v) < (longint'(1) << w));
   endfunction

   // FAULT keeps pumping and keeps the door shut until the drum reports empty
   function automatic act_t decode_act(input state_e s, input logic empty);
      act_t a;
      a = '0;
      case (s)
         FILL:  a.valve  = 1'b1;
         HEAT:  a.heater = 1'b1;
         WASH:  a.motor  = 1'b1;
         DRAIN: a.pump   = 1'b1;
         SPIN: begin
            a.motor = 1'b1;
            a.spin  = 1'b1;
            a.pump  = 1'b1;
         end
         FAULT: a.pump   = !empty;
         default: ;
      endcase
      a.door_lock = (s == FAULT) ? !empty : ((s != IDLE) && (s != DONE));
      return a;
   endfunction

endpackage

// File: rtl/wm_phase_timer.sv
// rtl/wm_phase_timer.sv - saturating phase timer with clear and compare-to-limit expiry
module wm_phase_timer #(
   parameter int TIMER_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic [TIMER_W-1:0] limit,
   output logic               expired
);

   logic [TIMER_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (count != '1) begin
         count <= count + TIMER_W'(1);
      end
   end

   // last cycle of the phase, so the phase spans exactly limit cycles
   assign expired = (count == (limit - TIMER_W'(1)));

endmodule

// File: rtl/washing_machine_prog.sv
// rtl/washing_machine_prog.sv - programmable washer sequencer with rinse passes, abort, door and watchdog supervision
module washing_machine_prog
   import washing_pkg::*;
#(
   parameter int TIMER_W       = 16,
   parameter int WASH_CYCLES   = 1000,
   parameter int RINSE_CYCLES  = 400,
   parameter int RINSE_COUNT   = 2,
   parameter int SPIN_CYCLES   = 500,
   parameter int FILL_TIMEOUT  = 4000,
   parameter int HEAT_TIMEOUT  = 8000,
   parameter int DRAIN_TIMEOUT = 2000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       cold,
   input  logic       door_closed,
   input  logic       full,
   input  logic       empty,
   input  logic       hot,
   input  logic       clean,
   output logic       heater,
   output logic       valve,
   output logic       motor,
   output logic       spin,
   output logic       pump,
   output logic       door_lock,
   output logic       busy,
   output logic       done,
   output logic       fault,
   output logic [2:0] phase
);

   localparam int RC_W = (RINSE_COUNT > 0) ? $clog2(RINSE_COUNT + 1) : 1;
   localparam logic [RC_W-1:0]    RC_MAX  = RC_W'(RINSE_COUNT);
   localparam logic [TIMER_W-1:0] L_WASH  = TIMER_W'(WASH_CYCLES);
   localparam logic [TIMER_W-1:0] L_RINSE = TIMER_W'(RINSE_CYCLES);
   localparam logic [TIMER_W-1:0] L_SPIN  = TIMER_W'(SPIN_CYCLES);
   localparam logic [TIMER_W-1:0] L_FILL  = TIMER_W'(FILL_TIMEOUT);
   localparam logic [TIMER_W-1:0] L_HEAT  = TIMER_W'(HEAT_TIMEOUT);
   localparam logic [TIMER_W-1:0] L_DRAIN = TIMER_W'(DRAIN_TIMEOUT);

   if (!(cycles_ok(WASH_CYCLES, TIMER_W) && cycles_ok(RINSE_CYCLES, TIMER_W) &&
         cycles_ok(SPIN_CYCLES, TIMER_W) && cycles_ok(FILL_TIMEOUT, TIMER_W) &&
         cycles_ok(HEAT_TIMEOUT, TIMER_W) && cycles_ok(DRAIN_TIMEOUT, TIMER_W))) begin : g_bad_cycles
      $error("washing_machine_prog: cycle parameter out of range for TIMER_W");
   end

   state_e             state, next_state;
   logic [RC_W-1:0]    rinse_cnt;
   logic               abort_q, cold_q, set_abort, expired, main_pass;
   logic [TIMER_W-1:0] limit;
   act_t               act;

   assign main_pass = (rinse_cnt == '0);

   wm_phase_timer #(.TIMER_W(TIMER_W)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (next_state != state),
      .limit   (limit),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rinse_cnt <= '0;
         abort_q   <= 1'b0;
         cold_q    <= 1'b0;
      end else begin
         state   <= next_state;
         abort_q <= (next_state == IDLE) ? 1'b0 : (abort_q | set_abort);
         if (state == IDLE && next_state == FILL) begin
            rinse_cnt <= '0;
            cold_q    <= cold;
         end else if (state == DRAIN && next_state == FILL) begin
            rinse_cnt <= rinse_cnt + RC_W'(1);
         end
      end
   end

   // each active phase checks door, then abort, then its timer, then its sensor
   always_comb begin
      next_state = state;
      set_abort  = 1'b0;
      limit      = '1;
      unique case (state)
         IDLE: if (start && door_closed) next_state = FILL;
         FILL: begin
            limit = L_FILL;
            if (!door_closed)          next_state = FAULT;
            else if (abort)            begin next_state = DRAIN; set_abort = 1'b1; end
            else if (expired && !full) next_state = FAULT;
            else if (full)             next_state = (main_pass && !cold_q) ? HEAT : WASH;
         end
         HEAT: begin
            limit = L_HEAT;
            if (!door_closed) next_state = FAULT;
            else if (abort)   begin next_state = DRAIN; set_abort = 1'b1; end
            else if (expired) next_state = FAULT;
            else if (hot)     next_state = WASH;
         end
         WASH: begin
            limit = main_pass ? L_WASH : L_RINSE;
            if (!door_closed)                     next_state = FAULT;
            else if (abort)                       begin next_state = DRAIN; set_abort = 1'b1; end
            else if (expired || (clean && main_pass)) next_state = DRAIN;
         end
         DRAIN: begin
            limit = L_DRAIN;
            if (!door_closed) next_state = FAULT;
            else begin
               set_abort = abort;
               if (expired)    next_state = FAULT;
               else if (empty) next_state = (abort_q || abort) ? IDLE :
                                            (rinse_cnt < RC_MAX) ? FILL : SPIN;
            end
         end
         SPIN: begin
            limit = L_SPIN;
            if (!door_closed) next_state = FAULT;
            else if (abort)   begin next_state = DRAIN; set_abort = 1'b1; end
            else if (expired) next_state = DONE;
         end
         DONE:  next_state = IDLE;
         FAULT: if (start && empty) next_state = IDLE;
      endcase
   end

   assign act       = decode_act(state, empty);
   assign heater    = act.heater;
   assign valve     = act.valve;
   assign motor     = act.motor;
   assign spin      = act.spin;
   assign pump      = act.pump;
   assign door_lock = act.door_lock;
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign fault     = (state == FAULT);
   assign phase     = state;

endmodule

// File: tb/tb_washing_machine_prog.sv
// tb/tb_washing_machine_prog.sv - directed self-checking bench for washing_machine_prog
module tb_washing_machine_prog;
   import washing_pkg::*;

   logic clk = 1'b0;
   logic rst_n, start, abort, cold, door_closed, full, empty, hot, clean;
   logic heater, valve, motor, spin, pump, door_lock, busy, done, fault;
   logic [2:0] phase;
   int n_cmp = 0;
   int n_err = 0;
   int done_cyc = 0;
   int heater_cyc = 0;
   int snap;

   washing_machine_prog #(
      .TIMER_W(16), .WASH_CYCLES(8), .RINSE_CYCLES(4), .RINSE_COUNT(1), .SPIN_CYCLES(4),
      .FILL_TIMEOUT(16), .HEAT_TIMEOUT(16), .DRAIN_TIMEOUT(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cold(cold),
      .door_closed(door_closed), .full(full), .empty(empty), .hot(hot), .clean(clean),
      .heater(heater), .valve(valve), .motor(motor), .spin(spin), .pump(pump),
      .door_lock(door_lock), .busy(busy), .done(done), .fault(fault), .phase(phase)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done)   done_cyc++;
      if (heater) heater_cyc++;
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // steps until the phase changes (bounded) and checks how long it lasted
   task automatic run_phase(input string tag, input logic [2:0] p, input int exp_len);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (phase == p && n < 64);
      check(tag, n, exp_len);
   endtask

   function automatic logic [5:0] acts();
      return {heater, valve, motor, spin, pump, door_lock};
   endfunction

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; cold = 1'b0; door_closed = 1'b1;
      full = 1'b0; empty = 1'b1; hot = 1'b0; clean = 1'b0;
      #3;
      check("rst_phase", phase, IDLE);
      check("rst_outs", {acts(), busy, done, fault}, 0);
      #9 rst_n = 1'b1;

      // 1: full hot program with one rinse pass
      start = 1'b1; step(); start = 1'b0; empty = 1'b0;
      check("t1_fill", phase, FILL);
      check("t1_fill_act", {acts(), busy}, 7'b0100011);
      step(2); full = 1'b1; step(); full = 1'b0;
      check("t1_heat", phase, HEAT);
      check("t1_heat_act", acts(), 6'b100001);
      step(2); hot = 1'b1; step(); hot = 1'b0;
      check("t1_wash", phase, WASH);
      check("t1_wash_act", acts(), 6'b001001);
      run_phase("t1_wash_len", WASH, 8);
      check("t1_drain", phase, DRAIN);
      check("t1_drain_act", acts(), 6'b000011);
      step(2); empty = 1'b1; step();
      check("t1_rinse_fill", phase, FILL);
      empty = 1'b0; step(2); full = 1'b1; step(); full = 1'b0;
      check("t1_rinse_wash", phase, WASH);
      run_phase("t1_rinse_len", WASH, 4);
      check("t1_drain2", phase, DRAIN);
      empty = 1'b1; step();
      check("t1_spin", phase, SPIN);
      check("t1_spin_act", acts(), 6'b001111);
      run_phase("t1_spin_len", SPIN, 4);
      check("t1_done", {phase, done, door_lock}, {DONE, 1'b1, 1'b0});
      step();
      check("t1_idle", {phase, done, busy}, {IDLE, 1'b0, 1'b0});
      check("t1_done_count", done_cyc, 1);

      // 2: cold program never heats
      snap = heater_cyc;
      cold = 1'b1; start = 1'b1; step(); start = 1'b0; cold = 1'b0; empty = 1'b0;
      step(); full = 1'b1; step(); full = 1'b0;
      check("t2_skip_heat", phase, WASH);
      run_phase("t2_wash_len", WASH, 8);
      empty = 1'b1; step();
      check("t2_rinse_fill", phase, FILL);
      empty = 1'b0; full = 1'b1; step(); full = 1'b0;
      check("t2_rinse_wash", phase, WASH);
      run_phase("t2_rinse_len", WASH, 4);
      empty = 1'b1; step();
      run_phase("t2_spin_len", SPIN, 4);
      step();
      check("t2_idle", phase, IDLE);
      check("t2_heater_cycles", heater_cyc - snap, 0);
      check("t2_done_count", done_cyc, 2);

      // 3: fill watchdog
      start = 1'b1; step(); start = 1'b0; empty = 1'b0;
      run_phase("t3_fill_timeout", FILL, 16);
      check("t3_fault", {phase, fault, pump, door_lock, busy}, {FAULT, 4'b1111});
      start = 1'b1; step(); start = 1'b0;
      check("t3_hold_not_empty", phase, FAULT);
      empty = 1'b1; #1;
      check("t3_fault_empty_act", {pump, door_lock, fault}, 3'b001);
      start = 1'b1; step(); start = 1'b0;
      check("t3_clear", {phase, fault}, {IDLE, 1'b0});

      // 4: abort mid-wash, then abort on the wash expiry cycle
      snap = done_cyc;
      start = 1'b1; step(); start = 1'b0; empty = 1'b0; full = 1'b1; step(); full = 1'b0;
      hot = 1'b1; step(); hot = 1'b0;
      check("t4_wash", phase, WASH);
      step(3); abort = 1'b1; step(); abort = 1'b0;
      check("t4_abort_drain", {phase, pump}, {DRAIN, 1'b1});
      step(); empty = 1'b1; step();
      check("t4_abort_idle", {phase, done}, {IDLE, 1'b0});
      start = 1'b1; step(); start = 1'b0; empty = 1'b0; full = 1'b1; step(); full = 1'b0;
      hot = 1'b1; step(); hot = 1'b0;
      step(7); abort = 1'b1; step(); abort = 1'b0;
      check("t4_expiry_abort_drain", phase, DRAIN);
      empty = 1'b1; step();
      check("t4_expiry_abort_idle", phase, IDLE);
      check("t4_no_done", done_cyc - snap, 0);

      // 5: door opened during spin; door open plus abort together
      cold = 1'b1; start = 1'b1; step(); start = 1'b0; cold = 1'b0; empty = 1'b0;
      full = 1'b1; step(); full = 1'b0;
      clean = 1'b1; step(); clean = 1'b0;
      check("t5_clean_exit", phase, DRAIN);
      empty = 1'b1; step(); empty = 1'b0; full = 1'b1; step(); full = 1'b0;
      run_phase("t5_rinse_len", WASH, 4);
      empty = 1'b1; step();
      check("t5_spin", phase, SPIN);
      step(); door_closed = 1'b0; step(); door_closed = 1'b1;
      check("t5_door_fault", {phase, spin, motor, fault}, {FAULT, 3'b001});
      start = 1'b1; step(); start = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      check("t5_fill", phase, FILL);
      door_closed = 1'b0; abort = 1'b1; step(); door_closed = 1'b1; abort = 1'b0;
      check("t5_door_beats_abort", phase, FAULT);
      start = 1'b1; step(); start = 1'b0;
      check("t5_clear", phase, IDLE);

      // 6: door-open start ignored; async reset mid-wash
      door_closed = 1'b0; start = 1'b1; step(); start = 1'b0; door_closed = 1'b1;
      check("t6_door_open_start", phase, IDLE);
      start = 1'b1; step(); start = 1'b0; empty = 1'b0; full = 1'b1; step(); full = 1'b0;
      hot = 1'b1; step(); hot = 1'b0;
      check("t6_wash", phase, WASH);
      step(2); #2 rst_n = 1'b0; #1;
      check("t6_async_reset", {phase, acts(), busy, done, fault}, 0);
      #2 rst_n = 1'b1; empty = 1'b1;
      cold = 1'b1; start = 1'b1; step(); start = 1'b0; cold = 1'b0;
      check("t6_restart_fill", phase, FILL);
      empty = 1'b0; full = 1'b1; step(); full = 1'b0;
      run_phase("t6_main_wash_len", WASH, 8);
      empty = 1'b1; step();
      check("t6_rinse_available", phase, FILL);
      abort = 1'b1; step(); abort = 1'b0; step();
      check("t6_abort_idle", phase, IDLE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
